// File: rtl/rv32_pkg.sv
// Shared RV32 types and constants for the barrel-core PC unit.
package rv32_pkg;

  typedef logic [31:0] rv32_pc_cnt_t;
  typedef logic [31:0] rv32_imm_t;
  typedef logic [31:0] rv32_register_t;

  localparam int unsigned RV32_ILEN_BYTES = 4;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ALU   = 4'd1,
    OP_LUI   = 4'd2,
    OP_AUIPC = 4'd3,
    OP_JAL   = 4'd4,
    OP_JALR  = 4'd5,
    OP_BEQ   = 4'd6,
    OP_BNE   = 4'd7,
    OP_BLT   = 4'd8,
    OP_BGE   = 4'd9,
    OP_BLTU  = 4'd10,
    OP_BGEU  = 4'd11,
    OP_LOAD  = 4'd12,
    OP_STORE = 4'd13
  } rv32_opcode_enum_t;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic rv32_pc_cnt_t pc_next_seq(input rv32_pc_cnt_t pc);
    return pc + rv32_pc_cnt_t'(RV32_ILEN_BYTES);
  endfunction

  // Target alignment check: every target must be word aligned.
  function automatic logic pc_misaligned(input rv32_pc_cnt_t pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/rv32_hart_rr_sel.sv
// Cyclic priority selector: lowest-index enabled hart at or after ptr.
module rv32_hart_rr_sel
  import rv32_pkg::*;
#(
  parameter int NUM_HARTS = 8,
  parameter int HART_W    = $clog2(NUM_HARTS)
) (
  input  logic [NUM_HARTS-1:0] hart_en,
  input  logic [HART_W-1:0]    ptr,
  output logic                 sel_valid,
  output logic [HART_W-1:0]    sel_id
);

  logic [HART_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest enabled hart wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    idx       = '0;
    for (int k = NUM_HARTS - 1; k >= 0; k--) begin
      idx = ptr + HART_W'(k);
      if (hart_en[idx]) begin
        sel_valid = 1'b1;
        sel_id    = idx;
      end
    end
  end

endmodule

// File: rtl/rv32_barrel_pc_unit.sv
// Per-hart PC unit for the barrel core: round-robin fetch issue plus
// jump/branch redirect resolution with link and misaligned-target trap.
module rv32_barrel_pc_unit
  import rv32_pkg::*;
#(
  parameter int           NUM_HARTS = 8,
  parameter int           HART_W    = $clog2(NUM_HARTS),
  parameter rv32_pc_cnt_t RESET_VEC = 32'h0000_0000,
  parameter rv32_pc_cnt_t TRAP_VEC  = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_HARTS-1:0] hart_en,
  input  logic               stall,
  output logic               fetch_valid,
  output logic [HART_W-1:0]  fetch_hart_id,
  output rv32_pc_cnt_t       fetch_pc,
  input  logic               exe_valid,
  input  logic [HART_W-1:0]  exe_hart_id,
  input  rv32_opcode_enum_t  exe_opcode,
  input  rv32_pc_cnt_t       exe_pc,
  input  rv32_register_t     exe_alu_res,
  input  rv32_register_t     exe_rs1,
  input  rv32_imm_t          exe_imm,
  output logic               wb_save_pc,
  output logic [HART_W-1:0]  wb_hart_id,
  output rv32_pc_cnt_t       wb_link,
  output logic               exc_misaligned,
  output rv32_pc_cnt_t       exc_tval
);

  rv32_pc_cnt_t      pc_q [NUM_HARTS];
  logic [HART_W-1:0] ptr_q;

  logic              sel_valid;
  logic [HART_W-1:0] sel_id;
  logic              issue_p0;

  logic              redir_p0;
  logic              link_p0;
  logic              misal_p0;
  rv32_pc_cnt_t      tgt_p0;
  rv32_pc_cnt_t      redir_pc_p0;

  rv32_hart_rr_sel #(
    .NUM_HARTS (NUM_HARTS),
    .HART_W    (HART_W)
  ) u_rr_sel (
    .hart_en   (hart_en),
    .ptr       (ptr_q),
    .sel_valid (sel_valid),
    .sel_id    (sel_id)
  );

  // ---- issue stage: fetch PC straight from the PC array ----
  assign issue_p0      = sel_valid & ~stall & ~rst;
  assign fetch_valid   = issue_p0;
  assign fetch_hart_id = issue_p0 ? sel_id : '0;
  assign fetch_pc      = issue_p0 ? pc_q[sel_id] : '0;

  // ---- execute stage: resolve redirect target and link decision ----
  always_comb begin
    redir_p0 = 1'b0;
    link_p0  = 1'b0;
    tgt_p0   = exe_pc + exe_imm;
    if (exe_valid) begin
      case (exe_opcode)
        OP_JAL: begin
          redir_p0 = 1'b1;
          link_p0  = 1'b1;
        end
        OP_JALR: begin
          redir_p0 = 1'b1;
          link_p0  = 1'b1;
          tgt_p0   = (exe_rs1 + exe_imm) & ~rv32_pc_cnt_t'(1);
        end
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
          redir_p0 = (exe_alu_res == 32'd1);
        end
        default: begin
          redir_p0 = 1'b0;
        end
      endcase
    end
  end

  assign misal_p0    = pc_misaligned(tgt_p0);
  assign redir_pc_p0 = misal_p0 ? TRAP_VEC : tgt_p0;

  // PC array update: a redirect of a hart overrides its same-cycle +4.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_HARTS; i++) pc_q[i] <= RESET_VEC;
    end else begin
      for (int i = 0; i < NUM_HARTS; i++) begin
        if (redir_p0 && (exe_hart_id == HART_W'(i))) begin
          pc_q[i] <= redir_pc_p0;
        end else if (issue_p0 && (sel_id == HART_W'(i))) begin
          pc_q[i] <= pc_next_seq(pc_q[i]);
        end
      end
    end
  end

  // Issue pointer advances past the hart just issued; holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (issue_p0) begin
      ptr_q <= sel_id + HART_W'(1);
    end
  end

  // ---- writeback stage: registered link and trap reporting ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_save_pc     <= 1'b0;
      wb_hart_id     <= '0;
      wb_link        <= '0;
      exc_misaligned <= 1'b0;
      exc_tval       <= '0;
    end else begin
      wb_save_pc     <= redir_p0 & link_p0 & ~misal_p0;
      exc_misaligned <= redir_p0 & misal_p0;
      if (redir_p0) wb_hart_id <= exe_hart_id;
      if (redir_p0 && link_p0 && !misal_p0) wb_link <= pc_next_seq(exe_pc);
      if (redir_p0 && misal_p0) exc_tval <= tgt_p0;
    end
  end

endmodule

// File: tb/tb_rv32_barrel_pc_unit.sv
// Self-checking bench for rv32_barrel_pc_unit: fetch and writeback scoreboards.
module tb_rv32_barrel_pc_unit;
  import rv32_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        hart_en;
  logic              stall;
  logic              fetch_valid;
  logic [2:0]        fetch_hart_id;
  logic [31:0]       fetch_pc;
  logic              exe_valid;
  logic [2:0]        exe_hart_id;
  rv32_opcode_enum_t exe_opcode;
  logic [31:0]       exe_pc, exe_alu_res, exe_rs1, exe_imm;
  logic              wb_save_pc;
  logic [2:0]        wb_hart_id;
  logic [31:0]       wb_link;
  logic              exc_misaligned;
  logic [31:0]       exc_tval;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic        v;
    logic [2:0]  id;
    logic [31:0] pc;
  } fexp_t;

  typedef struct packed {
    logic        save;
    logic        exc;
    logic [2:0]  id;
    logic [31:0] link;
    logic [31:0] tval;
  } wexp_t;

  fexp_t fq[$];
  wexp_t wq[$];
  fexp_t f;
  wexp_t w;

  localparam wexp_t W_QUIET = '{save: 1'b0, exc: 1'b0, id: 3'd0, link: 32'h0, tval: 32'h0};

  rv32_barrel_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .hart_en        (hart_en),
    .stall          (stall),
    .fetch_valid    (fetch_valid),
    .fetch_hart_id  (fetch_hart_id),
    .fetch_pc       (fetch_pc),
    .exe_valid      (exe_valid),
    .exe_hart_id    (exe_hart_id),
    .exe_opcode     (exe_opcode),
    .exe_pc         (exe_pc),
    .exe_alu_res    (exe_alu_res),
    .exe_rs1        (exe_rs1),
    .exe_imm        (exe_imm),
    .wb_save_pc     (wb_save_pc),
    .wb_hart_id     (wb_hart_id),
    .wb_link        (wb_link),
    .exc_misaligned (exc_misaligned),
    .exc_tval       (exc_tval)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exe();
    exe_valid = 1'b0; exe_hart_id = '0; exe_opcode = OP_NOP;
    exe_pc = '0; exe_alu_res = '0; exe_rs1 = '0; exe_imm = '0;
  endtask

  task automatic drive_exe(input rv32_opcode_enum_t op, input logic [2:0] h,
                           input logic [31:0] pc, input logic [31:0] alu,
                           input logic [31:0] rs1, input logic [31:0] imm);
    exe_valid = 1'b1; exe_opcode = op; exe_hart_id = h;
    exe_pc = pc; exe_alu_res = alu; exe_rs1 = rs1; exe_imm = imm;
  endtask

  task automatic do_reset();
    rst = 1'b1; hart_en = '0; stall = 1'b0; clear_exe();
    next_cycle(); next_cycle();
    rst = 1'b0;
    fq.delete(); wq.delete();
  endtask

  task automatic test_reset();
    // Pending exe work and enabled harts must all be ignored while in reset.
    rst = 1'b1; hart_en = 8'hFF; stall = 1'b0;
    drive_exe(OP_JAL, 3'd2, 32'h10, 32'h0, 32'h0, 32'h20);
    next_cycle(); next_cycle(); next_cycle();
    @(negedge clk);
    tests_run++;
    if (fetch_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_fetch_valid: got %b want 0", fetch_valid);
    end
    tests_run++;
    if ({wb_save_pc, exc_misaligned} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 00", {wb_save_pc, exc_misaligned});
    end
    tests_run++;
    if ({wb_hart_id, wb_link, exc_tval} !== '0) begin
      tests_failed++; $display("FAIL reset_data: got %h/%h/%h want 0/0/0", wb_hart_id, wb_link, exc_tval);
    end
    clear_exe();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({fetch_valid, fetch_hart_id, fetch_pc} !== {1'b1, 3'd0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_first_fetch: got v=%b id=%0d pc=%h want v=1 id=0 pc=00000000",
               fetch_valid, fetch_hart_id, fetch_pc);
    end
    next_cycle();
  endtask

  task automatic test_all_enabled();
    do_reset();
    hart_en = 8'hFF;
    for (int i = 0; i < 16; i++)
      fq.push_back('{v: 1'b1, id: 3'(i % 8), pc: (i < 8) ? 32'h0 : 32'h4});
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      f = fq.pop_front();
      tests_run++;
      if ({fetch_valid, fetch_hart_id, fetch_pc} !== {f.v, f.id, f.pc}) begin
        tests_failed++;
        $display("FAIL all_en_fetch[%0d]: got v=%b id=%0d pc=%h want v=%b id=%0d pc=%h",
                 i, fetch_valid, fetch_hart_id, fetch_pc, f.v, f.id, f.pc);
      end
      next_cycle();
    end
  endtask

  task automatic test_sparse();
    logic [2:0] order [4];
    order[0] = 3'd0; order[1] = 3'd2; order[2] = 3'd5; order[3] = 3'd7;
    do_reset();
    hart_en = 8'b1010_0101;
    for (int i = 0; i < 8; i++)
      fq.push_back('{v: 1'b1, id: order[i % 4], pc: (i < 4) ? 32'h0 : 32'h4});
    fq.push_back('{v: 1'b1, id: 3'd1, pc: 32'h0});
    for (int i = 0; i < 9; i++) begin
      if (i == 8) hart_en = 8'b0000_0010;
      @(negedge clk);
      f = fq.pop_front();
      tests_run++;
      if ({fetch_valid, fetch_hart_id, fetch_pc} !== {f.v, f.id, f.pc}) begin
        tests_failed++;
        $display("FAIL sparse_fetch[%0d]: got v=%b id=%0d pc=%h want v=%b id=%0d pc=%h",
                 i, fetch_valid, fetch_hart_id, fetch_pc, f.v, f.id, f.pc);
      end
      next_cycle();
    end
  endtask

  task automatic test_jal();
    do_reset();
    hart_en = 8'h00;
    drive_exe(OP_JAL, 3'd3, 32'h20, 32'h0, 32'h0, 32'h40);
    wq.push_back('{save: 1'b1, exc: 1'b0, id: 3'd3, link: 32'h24, tval: 32'h0});
    @(negedge clk);
    tests_run++;
    if (fetch_valid !== 1'b0) begin
      tests_failed++; $display("FAIL jal_no_enable_fetch: got %b want 0", fetch_valid);
    end
    next_cycle();
    clear_exe();
    hart_en = 8'h08;
    @(negedge clk);
    w = wq.pop_front();
    tests_run++;
    if (wb_save_pc !== w.save || exc_misaligned !== w.exc || wb_hart_id !== w.id || wb_link !== w.link) begin
      tests_failed++;
      $display("FAIL jal_wb: got save=%b exc=%b id=%0d link=%h want save=%b exc=%b id=%0d link=%h",
               wb_save_pc, exc_misaligned, wb_hart_id, wb_link, w.save, w.exc, w.id, w.link);
    end
    tests_run++;
    if ({fetch_valid, fetch_hart_id, fetch_pc} !== {1'b1, 3'd3, 32'h60}) begin
      tests_failed++;
      $display("FAIL jal_fetch: got v=%b id=%0d pc=%h want v=1 id=3 pc=00000060",
               fetch_valid, fetch_hart_id, fetch_pc);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if ({wb_save_pc, fetch_pc} !== {1'b0, 32'h64}) begin
      tests_failed++;
      $display("FAIL jal_after: got save=%b pc=%h want save=0 pc=00000064", wb_save_pc, fetch_pc);
    end
    next_cycle();
  endtask

  task automatic test_jalr_misaligned();
    do_reset();
    hart_en = 8'h00;
    drive_exe(OP_JALR, 3'd5, 32'h8, 32'h0, 32'h1003, 32'h0);
    wq.push_back('{save: 1'b0, exc: 1'b1, id: 3'd5, link: 32'h0, tval: 32'h1002});
    next_cycle();
    clear_exe();
    hart_en = 8'h20;
    @(negedge clk);
    w = wq.pop_front();
    tests_run++;
    if (wb_save_pc !== w.save || exc_misaligned !== w.exc || wb_hart_id !== w.id || exc_tval !== w.tval) begin
      tests_failed++;
      $display("FAIL jalr_trap_wb: got save=%b exc=%b id=%0d tval=%h want save=%b exc=%b id=%0d tval=%h",
               wb_save_pc, exc_misaligned, wb_hart_id, exc_tval, w.save, w.exc, w.id, w.tval);
    end
    tests_run++;
    if ({fetch_valid, fetch_hart_id, fetch_pc} !== {1'b1, 3'd5, 32'h100}) begin
      tests_failed++;
      $display("FAIL jalr_trap_fetch: got v=%b id=%0d pc=%h want v=1 id=5 pc=00000100",
               fetch_valid, fetch_hart_id, fetch_pc);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if ({exc_misaligned, fetch_pc} !== {1'b0, 32'h104}) begin
      tests_failed++;
      $display("FAIL jalr_pulse_end: got exc=%b pc=%h want exc=0 pc=00000104", exc_misaligned, fetch_pc);
    end
    next_cycle();
  endtask

  task automatic test_no_redirect();
    do_reset();
    hart_en = 8'h04;
    wq.push_back(W_QUIET);
    for (int c = 0; c < 4; c++) begin
      clear_exe();
      if (c == 0) drive_exe(OP_BNE, 3'd2, 32'h0, 32'h0, 32'h0, 32'h40);
      if (c == 1) drive_exe(OP_AUIPC, 3'd2, 32'h4, 32'h1, 32'h0, 32'h40);
      wq.push_back(W_QUIET);
      @(negedge clk);
      w = wq.pop_front();
      tests_run++;
      if (wb_save_pc !== w.save || exc_misaligned !== w.exc) begin
        tests_failed++;
        $display("FAIL noredir_wb[%0d]: got save=%b exc=%b want save=0 exc=0", c, wb_save_pc, exc_misaligned);
      end
      tests_run++;
      if ({fetch_valid, fetch_hart_id, fetch_pc} !== {1'b1, 3'd2, 32'(4 * c)}) begin
        tests_failed++;
        $display("FAIL noredir_fetch[%0d]: got v=%b id=%0d pc=%h want v=1 id=2 pc=%h",
                 c, fetch_valid, fetch_hart_id, fetch_pc, 32'(4 * c));
      end
      next_cycle();
    end
    clear_exe();
  endtask

  task automatic test_branch_taken();
    do_reset();
    hart_en = 8'h00;
    drive_exe(OP_BGEU, 3'd6, 32'h10, 32'h1, 32'h0, 32'h10);
    wq.push_back(W_QUIET);
    next_cycle();
    hart_en = 8'h40;
    // Taken branch to a misaligned target in the same cycle hart 6 issues.
    drive_exe(OP_BEQ, 3'd6, 32'h20, 32'h1, 32'h0, 32'h2);
    @(negedge clk);
    w = wq.pop_front();
    tests_run++;
    if (wb_save_pc !== w.save || exc_misaligned !== w.exc) begin
      tests_failed++;
      $display("FAIL branch_no_link: got save=%b exc=%b want save=0 exc=0", wb_save_pc, exc_misaligned);
    end
    tests_run++;
    if ({fetch_valid, fetch_hart_id, fetch_pc} !== {1'b1, 3'd6, 32'h20}) begin
      tests_failed++;
      $display("FAIL branch_taken_fetch: got v=%b id=%0d pc=%h want v=1 id=6 pc=00000020",
               fetch_valid, fetch_hart_id, fetch_pc);
    end
    wq.push_back('{save: 1'b0, exc: 1'b1, id: 3'd6, link: 32'h0, tval: 32'h22});
    next_cycle();
    clear_exe();
    @(negedge clk);
    w = wq.pop_front();
    tests_run++;
    if (wb_save_pc !== w.save || exc_misaligned !== w.exc || wb_hart_id !== w.id || exc_tval !== w.tval) begin
      tests_failed++;
      $display("FAIL branch_trap_wb: got save=%b exc=%b id=%0d tval=%h want save=%b exc=%b id=%0d tval=%h",
               wb_save_pc, exc_misaligned, wb_hart_id, exc_tval, w.save, w.exc, w.id, w.tval);
    end
    tests_run++;
    if (fetch_pc !== 32'h100) begin
      tests_failed++; $display("FAIL branch_trap_fetch: got pc=%h want pc=00000100", fetch_pc);
    end
    next_cycle();
  endtask

  task automatic test_collision_stall();
    logic [2:0] ids [13];
    logic [31:0] pcs [13];
    logic        vs  [13];
    do_reset();
    hart_en = 8'hFF;
    // Expected fetch stream: 0,1,2, three stalled cycles, then 3..7, 0 at 0x80, 1 at 0x4.
    for (int c = 0; c < 13; c++) begin
      vs[c] = 1'b1; pcs[c] = 32'h0; ids[c] = 3'd0;
    end
    ids[0] = 3'd0; ids[1] = 3'd1; ids[2] = 3'd2;
    vs[3] = 1'b0; vs[4] = 1'b0; vs[5] = 1'b0;
    ids[6] = 3'd3; ids[7] = 3'd4; pcs[7] = 32'h200; ids[8] = 3'd5; ids[9] = 3'd6;
    ids[10] = 3'd7; ids[11] = 3'd0; pcs[11] = 32'h80; ids[12] = 3'd1; pcs[12] = 32'h4;
    for (int c = 0; c < 13; c++) fq.push_back('{v: vs[c], id: ids[c], pc: pcs[c]});
    wq.push_back(W_QUIET);
    for (int c = 0; c < 13; c++) begin
      clear_exe();
      stall = (c >= 3 && c <= 5);
      if (c == 0) begin
        drive_exe(OP_JAL, 3'd0, 32'h40, 32'h0, 32'h0, 32'h40);
        wq.push_back('{save: 1'b1, exc: 1'b0, id: 3'd0, link: 32'h44, tval: 32'h0});
      end else if (c == 4) begin
        drive_exe(OP_JAL, 3'd4, 32'h0, 32'h0, 32'h0, 32'h200);
        wq.push_back('{save: 1'b1, exc: 1'b0, id: 3'd4, link: 32'h4, tval: 32'h0});
      end else begin
        wq.push_back(W_QUIET);
      end
      @(negedge clk);
      f = fq.pop_front();
      tests_run++;
      if (fetch_valid !== f.v || (f.v && (fetch_hart_id !== f.id || fetch_pc !== f.pc))) begin
        tests_failed++;
        $display("FAIL collide_fetch[%0d]: got v=%b id=%0d pc=%h want v=%b id=%0d pc=%h",
                 c, fetch_valid, fetch_hart_id, fetch_pc, f.v, f.id, f.pc);
      end
      w = wq.pop_front();
      tests_run++;
      if (wb_save_pc !== w.save || exc_misaligned !== w.exc ||
          (w.save && (wb_hart_id !== w.id || wb_link !== w.link))) begin
        tests_failed++;
        $display("FAIL collide_wb[%0d]: got save=%b exc=%b id=%0d link=%h want save=%b exc=%b id=%0d link=%h",
                 c, wb_save_pc, exc_misaligned, wb_hart_id, wb_link, w.save, w.exc, w.id, w.link);
      end
      next_cycle();
    end
    stall = 1'b0;
    clear_exe();
  endtask

  initial begin
    rst = 1'b1; hart_en = '0; stall = 1'b0; clear_exe();
    test_reset();
    test_all_enabled();
    test_sparse();
    test_jal();
    test_jalr_misaligned();
    test_no_redirect();
    test_branch_taken();
    test_collision_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
